// File: rtl/mux_scan_sequencer.sv
// Control stage for the mux16to1: latches a word, walks the mux select and returns the word as a serial stream.
// Optional MUX_SCAN_MSB_FIRST_EN reverses the scan direction (bit 15 first).
module mux_scan_sequencer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] load_data,
  output logic [15:0] mux_in,
  output logic [3:0]  sel,
  input  logic        mux_out,
  output logic        ser_bit,
  output logic        ser_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

`ifdef MUX_SCAN_MSB_FIRST_EN
  localparam logic [3:0] FIRST_IDX = 4'd15;
  localparam logic [3:0] LAST_IDX  = 4'd0;
  localparam logic [3:0] SEL_STEP  = 4'hF;
`else
  localparam logic [3:0] FIRST_IDX = 4'd0;
  localparam logic [3:0] LAST_IDX  = 4'd15;
  localparam logic [3:0] SEL_STEP  = 4'd1;
`endif

  state_t      state, state_nxt;
  logic [7:0]  hold_cnt, hold_nxt;
  logic [15:0] mux_in_nxt;
  logic [3:0]  sel_nxt;
  logic        ser_bit_nxt, ser_valid_nxt, busy_nxt, done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      mux_in    <= '0;
      sel       <= '0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      mux_in    <= mux_in_nxt;
      sel       <= sel_nxt;
      ser_bit   <= ser_bit_nxt;
      ser_valid <= ser_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Strobes and done are single-cycle, so they default low; everything else holds.
  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold_cnt;
    mux_in_nxt    = mux_in;
    sel_nxt       = sel;
    ser_bit_nxt   = ser_bit;
    ser_valid_nxt = 1'b0;
    busy_nxt      = busy;
    done_nxt      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          mux_in_nxt = load_data;
          sel_nxt    = FIRST_IDX;
          hold_nxt   = '0;
          busy_nxt   = 1'b1;
          state_nxt  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + 8'd1;
        end else begin
          ser_bit_nxt   = mux_out;
          ser_valid_nxt = 1'b1;
          hold_nxt      = '0;
          // The final index parks sel there so the last sampled position stays visible.
          if (sel == LAST_IDX) begin
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            sel_nxt = sel + SEL_STEP;
          end
        end
      end

      S_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (HOLD_CYCLES 1 and 3) each driving a behavioural 16:1 mux.
// Expected outputs come from a timing formula in cycles since the start was accepted.
module tb_mux_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start     [2];
  logic [15:0] load_data [2];
  logic [15:0] mux_in    [2];
  logic [3:0]  sel       [2];
  logic        mux_out   [2];
  logic        ser_bit   [2];
  logic        ser_valid [2];
  logic        busy      [2];
  logic        done      [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mux_out[0] = mux_in[0][sel[0]];
  assign mux_out[1] = mux_in[1][sel[1]];

  mux_scan_sequencer #(.HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .rst(rst), .start(start[0]), .load_data(load_data[0]),
    .mux_in(mux_in[0]), .sel(sel[0]), .mux_out(mux_out[0]), .ser_bit(ser_bit[0]),
    .ser_valid(ser_valid[0]), .busy(busy[0]), .done(done[0])
  );

  mux_scan_sequencer #(.HOLD_CYCLES(3)) dut_h3 (
    .clk(clk), .rst(rst), .start(start[1]), .load_data(load_data[1]),
    .mux_in(mux_in[1]), .sel(sel[1]), .mux_out(mux_out[1]), .ser_bit(ser_bit[1]),
    .ser_valid(ser_valid[1]), .busy(busy[1]), .done(done[1])
  );

  function automatic int hold_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Mux position visited at step k of a word (k = 0 is the first bit sent).
  function automatic int scan_idx(input int k);
`ifdef MUX_SCAN_MSB_FIRST_EN
    return 15 - k;
`else
    return k;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // n = clock edges since the edge that accepted word.
  task automatic checkOutput(input int d, input int n, input logic [15:0] word);
    int   h      = hold_of(d);
    int   last_n = 16 * h;
    int   k_sel  = (n < last_n) ? (n / h) : 15;
    logic e_busy, e_valid, e_done;
    e_busy  = (n <= last_n);
    e_valid = (n >= h) && (n <= last_n) && ((n % h) == 0);
    e_done  = (n == last_n);
    checkVal($sformatf("d%0d n%0d busy", d, n), 16'(busy[d]), 16'(e_busy));
    checkVal($sformatf("d%0d n%0d ser_valid", d, n), 16'(ser_valid[d]), 16'(e_valid));
    checkVal($sformatf("d%0d n%0d done", d, n), 16'(done[d]), 16'(e_done));
    checkVal($sformatf("d%0d n%0d sel", d, n), 16'(sel[d]), 16'(scan_idx(k_sel)));
    checkVal($sformatf("d%0d n%0d mux_in", d, n), mux_in[d], word);
    if (e_valid)
      checkVal($sformatf("d%0d n%0d ser_bit", d, n), 16'(ser_bit[d]),
               16'(word[scan_idx(n / h - 1)]));
  endtask

  task automatic checkAllZero(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkVal($sformatf("%s d%0d mux_in", tag, d), mux_in[d], 16'h0000);
      checkVal($sformatf("%s d%0d sel", tag, d), 16'(sel[d]), 16'h0000);
      checkVal($sformatf("%s d%0d outs", tag, d),
               16'({ser_bit[d], ser_valid[d], busy[d], done[d]}), 16'h0000);
    end
  endtask

  // Serialise one word; start is randomly re-asserted while it must be ignored.
  task automatic applyStimulus(input int d, input logic [15:0] word);
    int h = hold_of(d);
    start[d]     = 1'b1;
    load_data[d] = word;
    step();
    for (int n = 0; n <= 16 * h + 1; n++) begin
      if (n > 0) step();
      load_data[d] = 16'($urandom);
      start[d]     = (n <= 16 * h) ? 1'($urandom) : 1'b0;
      checkOutput(d, n, word);
    end
    start[d] = 1'b0;
  endtask

  // start held high with load_data changing every cycle: words repeat every 16*H+2 edges.
  task automatic streamTest();
    int          period = 16 * hold_of(0) + 2;
    int          n      = 0;
    int          words  = 1;
    logic [15:0] ld, cur;
    ld           = 16'($urandom);
    start[0]     = 1'b1;
    load_data[0] = ld;
    step();
    cur = ld;
    checkOutput(0, 0, cur);
    while (!(words == 3 && n == period - 1)) begin
      ld           = 16'($urandom);
      load_data[0] = ld;
      step();
      n++;
      if (n == period) begin
        n = 0;
        cur = ld;
        words++;
      end
      checkOutput(0, n, cur);
    end
    start[0] = 1'b0;
    step();
    checkOutput(0, period, cur);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] w0, w1;
    for (int d = 0; d < 2; d++) begin
      start[d]     = 1'b0;
      load_data[d] = 16'($urandom);
    end
    #2 rst = 1'b1;
    #1 checkAllZero("reset");
    step();
    step();
    rst = 1'b0;
    step();
    checkAllZero("idle");

    applyStimulus(0, 16'hA5C3);
    applyStimulus(1, 16'h8001);
    applyStimulus(0, 16'h0001);
    applyStimulus(0, 16'($urandom));
    applyStimulus(0, 16'($urandom));
    applyStimulus(1, 16'($urandom));

    streamTest();

    // Abandon a word mid-flight with an asynchronous reset.
    w0 = 16'($urandom);
    w1 = 16'($urandom);
    start[0] = 1'b1; load_data[0] = w0;
    start[1] = 1'b1; load_data[1] = w1;
    step();
    start[0] = 1'b0;
    start[1] = 1'b0;
    checkOutput(0, 0, w0);
    for (int n = 1; n <= 5; n++) begin
      step();
      checkOutput(0, n, w0);
      checkOutput(1, n, w1);
    end
    #2 rst = 1'b1;
    #1 checkAllZero("async_rst");
    start[0] = 1'b1;
    start[1] = 1'b1;
    step();
    checkAllZero("held_rst");
    start[0] = 1'b0;
    start[1] = 1'b0;
    rst = 1'b0;
    step();
    checkAllZero("post_rst");

    applyStimulus(0, 16'($urandom));
    applyStimulus(1, 16'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
